shapool_spi_daisy: RTL and testbench
====================================

# shapool_spi_daisy

Parametrised SPI slave shift unit for the shapool device chain. It generalises the fixed global and daisy SPI front-ends into one block with configurable frame width and synchroniser depth. It parallel-loads a result word at frame start, so the daisy chain reads results out while new data shifts in. All SPI pins are oversampled in the single `clk_in` domain. Complete frames are reported with `data_valid_out`; short frames are reported with `frame_error_out`.

## Interface
- `DATA_WIDTH`, 64: shift register and frame width in bits; must be ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops on `sck_in`, `sdi_in` and `cs_n_in`; must be ≥ 2.
- `clk_in` in 1: system clock; the only clock.
- `reset_in` in 1: synchronous, active-high reset.
- `sck_in` in 1: SPI clock, mode 0, asynchronous.
- `sdi_in` in 1: serial data in, MSB first, asynchronous.
- `cs_n_in` in 1: active-low chip select, asynchronous.
- `sdo_out` out 1: serial data out to the next device in the chain.
- `load_data_in` in DATA_WIDTH: word sampled on frame start and shifted out first.
- `data_out` out DATA_WIDTH: last DATA_WIDTH bits received in a valid frame.
- `data_valid_out` out 1: one-cycle pulse; `data_out` was updated in the same cycle.
- `frame_error_out` out 1: one-cycle pulse; the frame ended with 0 < bits < DATA_WIDTH.
- `busy_out` out 1: high while the FSM is in ACTIVE.

## Operation
- Synchronisers: each input passes through SYNC_STAGES flops, plus one history flop for edge detection. Reset values: sck = 0, sdi = 0, cs_n = 1.
- Edge signals are derived from the synchronised values: `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`.
- FSM states:
  - WAIT_IDLE (reset state): when synchronised cs_n = 1 → IDLE. All sck activity is ignored.
  - IDLE: on `cs_fall` → ACTIVE. Same cycle: `sr <= load_data_in`, `sdo_out <= load_data_in[DATA_WIDTH-1]`, `count <= 0`.
  - ACTIVE, on `sck_rise`: `sr <= {sr[DATA_WIDTH-2:0], sdi_sync}`; `count` increments, saturating at DATA_WIDTH.
  - ACTIVE, on `sck_fall`: `sdo_out <= sr[DATA_WIDTH-1]`.
  - ACTIVE, on `cs_rise` → IDLE:
    - `count == DATA_WIDTH`: `data_out <= sr`, pulse `data_valid_out`.
    - `0 < count < DATA_WIDTH`: pulse `frame_error_out`; `data_out` unchanged.
    - `count == 0`: no pulse.
- Daisy behaviour: a frame of N·DATA_WIDTH bits passes the first (N−1)·DATA_WIDTH bits through to `sdo_out`, delayed by DATA_WIDTH bits. The device keeps the last DATA_WIDTH bits received. Bit counts above DATA_WIDTH are valid.
- `count` width is `$clog2(DATA_WIDTH+1)`; it never wraps.
- `sdo_out` holds its value outside ACTIVE.

## Timing
- Reset values of outputs: `sdo_out` = 0, `data_out` = 0, `data_valid_out` = 0, `frame_error_out` = 0, `busy_out` = 0.
- Pin-to-action latency: SYNC_STAGES+1 `clk_in` edges, for every sck or cs edge.
- `data_valid_out` and `frame_error_out` assert SYNC_STAGES+1 cycles after cs_n rises at the pin. Each lasts exactly 1 cycle.
- Input requirements:
  - sck high and sck low each last ≥ SYNC_STAGES+1 clk cycles.
  - cs_n low-to-first-sck-rise ≥ SYNC_STAGES+2 cycles.
  - Last-sck-fall-to-cs_n-high ≥ 1 cycle.
- Simultaneous events:
  - `cs_rise` together with `sck_rise` or `sck_fall`: cs wins; the sck edge is ignored.
  - `cs_fall` in a state other than IDLE: ignored.
- Reset mid-frame: the frame is abandoned with no pulse and the FSM enters WAIT_IDLE. If cs_n is still low, the remainder of that frame is ignored. The next frame after cs_n goes high is handled normally.
- `busy_out` rises 1 cycle after `cs_fall` is detected and falls in the same cycle as the valid or error pulse.

## Test plan
- Normal frame (DATA_WIDTH=8): load 0xA5, shift in 0x3C, 8 bits. Required:
  - `sdo_out` sampled on sck rises = 1,0,1,0,0,1,0,1.
  - `data_out` = 0x3C with a 1-cycle `data_valid_out`.
- Daisy frame (DATA_WIDTH=8): load 0xA5, shift in 16 bits 0x12 then 0x34. Required:
  - `sdo_out` bits = 0xA5 then 0x12.
  - `data_out` = 0x34; exactly one `data_valid_out`.
- Short frame: 5 bits shifted. Required: one `frame_error_out` pulse, no `data_valid_out`, `data_out` keeps its previous value.
- Zero-length frame: cs_n low for 10 cycles then high, no sck. Required: no pulses; `busy_out` high for the frame duration.
- Reset mid-frame:
  - Stimulus: assert `reset_in` after 3 bits while cs_n stays low, then 5 more sck pulses, then cs_n high.
  - Required: no pulse and `busy_out` = 0 throughout.
  - Then a full 8-bit frame of 0x81 gives `data_out` = 0x81.
- Idle sck: 8 sck pulses with cs_n high. Required: `sdo_out`, `data_out` and the shift register are unchanged; no pulses.

Source files
------------

// File: rtl/shapool_spi_daisy.sv
// shapool_spi_daisy: oversampled SPI mode-0 slave shift unit with parallel result load for daisy chaining
// Ports:
//   clk_in, reset_in          system clock, synchronous active-high reset
//   sck_in, sdi_in, cs_n_in   asynchronous SPI pins
//   sdo_out                   serial data to the next device in the chain
//   load_data_in              word captured at frame start and shifted out first
//   data_out                  last DATA_WIDTH bits of the latest complete frame
//   data_valid_out            one-cycle pulse when data_out updates
//   frame_error_out           one-cycle pulse when a frame ends short
//   busy_out                  high while a frame is being received
module shapool_spi_daisy #(
    parameter int DATA_WIDTH  = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  sck_in,
    input  logic                  sdi_in,
    input  logic                  cs_n_in,
    output logic                  sdo_out,
    input  logic [DATA_WIDTH-1:0] load_data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  frame_error_out,
    output logic                  busy_out
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t                state, state_next;
    logic [SYNC_STAGES-1:0] sck_sync, sdi_sync_r, cs_sync;
    logic                  sck_h, cs_h;
    // Fills with ones after reset so WAIT_IDLE only trusts cs_n once the
    // synchroniser holds real pin samples instead of its reset value.
    logic [SYNC_STAGES:0]  flush;
    logic [DATA_WIDTH-1:0] sr;
    logic [CW-1:0]         count;
    logic                  sck_s, sdi_sync, cs_n_s;
    logic                  sck_rise, sck_fall, cs_fall, cs_rise;
    logic                  load, shift, drive, valid, err;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_sync = sdi_sync_r[SYNC_STAGES-1];
    assign cs_n_s   = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_h;
    assign sck_fall = ~sck_s & sck_h;
    assign cs_fall  = ~cs_n_s & cs_h;
    assign cs_rise  = cs_n_s & ~cs_h;
    assign busy_out = (state == ACTIVE);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sck_sync   <= '0;
            sdi_sync_r <= '0;
            cs_sync    <= '1;
            sck_h      <= 1'b0;
            cs_h       <= 1'b1;
            flush      <= '0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi_in};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
            sck_h      <= sck_s;
            cs_h       <= cs_n_s;
            flush      <= {flush[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        drive      = 1'b0;
        valid      = 1'b0;
        err        = 1'b0;
        case (state)
            WAIT_IDLE: state_next = (flush[SYNC_STAGES] && cs_n_s) ? IDLE : WAIT_IDLE;
            IDLE: begin
                load       = cs_fall;
                state_next = cs_fall ? ACTIVE : IDLE;
            end
            ACTIVE: begin
                // cs edge takes priority over any coincident sck edge
                state_next = cs_rise ? IDLE : ACTIVE;
                valid      = cs_rise && (count == FULL);
                err        = cs_rise && (count != '0) && (count != FULL);
                shift      = !cs_rise && sck_rise;
                drive      = !cs_rise && sck_fall;
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state           <= WAIT_IDLE;
            sr              <= '0;
            count           <= '0;
            sdo_out         <= 1'b0;
            data_out        <= '0;
            data_valid_out  <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            state           <= state_next;
            data_valid_out  <= valid;
            frame_error_out <= err;
            if (load) begin
                sr      <= load_data_in;
                sdo_out <= load_data_in[DATA_WIDTH-1];
                count   <= '0;
            end
            if (shift) begin
                sr    <= {sr[DATA_WIDTH-2:0], sdi_sync};
                count <= count + CW'(count != FULL);
            end
            if (drive) sdo_out <= sr[DATA_WIDTH-1];
            if (valid) data_out <= sr;
        end
    end
endmodule

// File: tb/tb_shapool_spi_daisy.sv
// tb_shapool_spi_daisy: directed self-checking bench for shapool_spi_daisy (DATA_WIDTH=8, SYNC_STAGES=2)
module tb_shapool_spi_daisy;
    logic       clk = 1'b0;
    logic       reset_in = 1'b1;
    logic       sck_in = 1'b0;
    logic       sdi_in = 1'b0;
    logic       cs_n_in = 1'b1;
    logic [7:0] load_data_in = 8'h00;
    logic       sdo_out;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic       frame_error_out;
    logic       busy_out;
    int checks = 0, passed = 0;
    int vcnt = 0, ecnt = 0, bcnt = 0;

    shapool_spi_daisy #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_in(clk), .reset_in(reset_in), .sck_in(sck_in), .sdi_in(sdi_in),
        .cs_n_in(cs_n_in), .sdo_out(sdo_out), .load_data_in(load_data_in),
        .data_out(data_out), .data_valid_out(data_valid_out),
        .frame_error_out(frame_error_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid_out) vcnt++;
        if (frame_error_out) ecnt++;
        if (busy_out) bcnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low;
        cs_n_in = 1'b0;
        clks(5);
    endtask

    task automatic bit_tx(input logic b, output logic s);
        sdi_in = b;
        clks(1);
        s = sdo_out;
        sck_in = 1'b1;
        clks(4);
        sck_in = 1'b0;
        clks(4);
    endtask

    task automatic send(input logic [15:0] d, input int n, output logic [15:0] got);
        logic s;
        got = '0;
        cs_low();
        for (int i = n - 1; i >= 0; i--) begin
            bit_tx(d[i], s);
            got = {got[14:0], s};
        end
        cs_n_in = 1'b1;
    endtask

    task automatic test_reset;
        reset_in = 1'b1;
        clks(3);
        checks++; if (sdo_out !== 1'b0) $display("FAIL rst_sdo got %b want 0", sdo_out); else passed++;
        checks++; if (data_out !== 8'h00) $display("FAIL rst_data got %h want 00", data_out); else passed++;
        checks++; if (data_valid_out !== 1'b0) $display("FAIL rst_valid got %b want 0", data_valid_out); else passed++;
        checks++; if (frame_error_out !== 1'b0) $display("FAIL rst_err got %b want 0", frame_error_out); else passed++;
        checks++; if (busy_out !== 1'b0) $display("FAIL rst_busy got %b want 0", busy_out); else passed++;
        reset_in = 1'b0;
        clks(6);
    endtask

    task automatic test_normal;
        logic [15:0] got;
        int v0;
        v0 = vcnt;
        load_data_in = 8'hA5;
        send(16'h003C, 8, got);
        clks(2);
        checks++; if (data_valid_out !== 1'b0) $display("FAIL norm_valid_early got %b want 0", data_valid_out); else passed++;
        checks++; if (busy_out !== 1'b1) $display("FAIL norm_busy_hold got %b want 1", busy_out); else passed++;
        clks(1);
        checks++; if (data_valid_out !== 1'b1) $display("FAIL norm_valid_edge got %b want 1", data_valid_out); else passed++;
        checks++; if (busy_out !== 1'b0) $display("FAIL norm_busy_fall got %b want 0", busy_out); else passed++;
        checks++; if (data_out !== 8'h3C) $display("FAIL norm_data got %h want 3c", data_out); else passed++;
        clks(1);
        checks++; if (data_valid_out !== 1'b0) $display("FAIL norm_valid_width got %b want 0", data_valid_out); else passed++;
        checks++; if (got[7:0] !== 8'hA5) $display("FAIL norm_sdo got %h want a5", got[7:0]); else passed++;
        clks(4);
        checks++; if (vcnt - v0 !== 1) $display("FAIL norm_valid_count got %0d want 1", vcnt - v0); else passed++;
    endtask

    task automatic test_daisy;
        logic [15:0] got;
        int v0;
        v0 = vcnt;
        load_data_in = 8'hA5;
        send(16'h1234, 16, got);
        clks(8);
        checks++; if (got !== 16'hA512) $display("FAIL daisy_sdo got %h want a512", got); else passed++;
        checks++; if (data_out !== 8'h34) $display("FAIL daisy_data got %h want 34", data_out); else passed++;
        checks++; if (vcnt - v0 !== 1) $display("FAIL daisy_valid_count got %0d want 1", vcnt - v0); else passed++;
    endtask

    task automatic test_short;
        logic [15:0] got;
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        load_data_in = 8'h00;
        send(16'h001F, 5, got);
        clks(2);
        checks++; if (frame_error_out !== 1'b0) $display("FAIL short_err_early got %b want 0", frame_error_out); else passed++;
        clks(1);
        checks++; if (frame_error_out !== 1'b1) $display("FAIL short_err_edge got %b want 1", frame_error_out); else passed++;
        clks(5);
        checks++; if (ecnt - e0 !== 1) $display("FAIL short_err_count got %0d want 1", ecnt - e0); else passed++;
        checks++; if (vcnt - v0 !== 0) $display("FAIL short_valid_count got %0d want 0", vcnt - v0); else passed++;
        checks++; if (data_out !== 8'h34) $display("FAIL short_data got %h want 34", data_out); else passed++;
    endtask

    task automatic test_zero;
        int v0, e0, b0;
        v0 = vcnt;
        e0 = ecnt;
        b0 = bcnt;
        cs_n_in = 1'b0;
        clks(10);
        cs_n_in = 1'b1;
        clks(6);
        checks++; if (vcnt - v0 !== 0) $display("FAIL zero_valid_count got %0d want 0", vcnt - v0); else passed++;
        checks++; if (ecnt - e0 !== 0) $display("FAIL zero_err_count got %0d want 0", ecnt - e0); else passed++;
        checks++; if (bcnt - b0 !== 10) $display("FAIL zero_busy_cycles got %0d want 10", bcnt - b0); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [15:0] got;
        logic s;
        int v0, e0, b0;
        load_data_in = 8'h00;
        cs_low();
        for (int i = 0; i < 3; i++) bit_tx(1'b1, s);
        reset_in = 1'b1;
        clks(2);
        reset_in = 1'b0;
        v0 = vcnt;
        e0 = ecnt;
        b0 = bcnt;
        checks++; if (busy_out !== 1'b0) $display("FAIL mid_busy_after_rst got %b want 0", busy_out); else passed++;
        for (int i = 0; i < 5; i++) bit_tx(i[0], s);
        cs_n_in = 1'b1;
        clks(8);
        checks++; if (vcnt - v0 + ecnt - e0 !== 0) $display("FAIL mid_pulses got %0d want 0", vcnt - v0 + ecnt - e0); else passed++;
        checks++; if (bcnt - b0 !== 0) $display("FAIL mid_busy_cycles got %0d want 0", bcnt - b0); else passed++;
        v0 = vcnt;
        send(16'h0081, 8, got);
        clks(6);
        checks++; if (data_out !== 8'h81) $display("FAIL mid_next_data got %h want 81", data_out); else passed++;
        checks++; if (vcnt - v0 !== 1) $display("FAIL mid_next_valid got %0d want 1", vcnt - v0); else passed++;
    endtask

    task automatic test_idle_sck;
        logic s;
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        load_data_in = 8'hFF;
        for (int i = 0; i < 8; i++) bit_tx(~i[0], s);
        clks(4);
        checks++; if (sdo_out !== 1'b1) $display("FAIL idle_sdo got %b want 1", sdo_out); else passed++;
        checks++; if (data_out !== 8'h81) $display("FAIL idle_data got %h want 81", data_out); else passed++;
        checks++; if (dut.sr !== 8'h81) $display("FAIL idle_sr got %h want 81", dut.sr); else passed++;
        checks++; if (vcnt - v0 + ecnt - e0 !== 0) $display("FAIL idle_pulses got %0d want 0", vcnt - v0 + ecnt - e0); else passed++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_daisy();
        test_short();
        test_zero();
        test_reset_mid();
        test_idle_sck();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
